// File: rtl/ins_mem.sv
// rtl/ins_mem.sv - byte-addressed little-endian instruction memory with word-streaming loader
// Optional fetch-fault output enabled by defining INS_MEM_FAULT_EN.
module ins_mem #(
    parameter int DEPTH     = 40,
    parameter int INS_START = 64,
    parameter int AW        = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   ins_addr,
    output logic [31:0]   ins_data,
    output logic          ins_fault,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW-1:0] ld_words,
    output logic          mem_ready
);
    localparam int NBYTES = DEPTH * 4;
    localparam int BW     = $clog2(NBYTES);

    typedef enum logic {LOAD, RUN} state_t;

    state_t        state;
    logic [7:0]    mem [NBYTES];
    logic [31:0]   offset;
    logic          in_range;
    logic [BW-1:0] rd_idx;
    logic [BW-1:0] wr_base;
    logic          xfer;
    logic          last_slot;

    assign xfer      = ld_ready & ld_valid;
    assign last_slot = (ld_words == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            ld_words  <= '0;
            ld_ready  <= 1'b1;
            mem_ready <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_start) begin
                        ld_words <= '0;
                    end else if (xfer) begin
                        ld_words <= ld_words + 1'b1;
                        // The last slot forces RUN so the pointer never wraps over word 0.
                        if (ld_last || last_slot) begin
                            state     <= RUN;
                            ld_ready  <= 1'b0;
                            mem_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ld_start) begin
                        state     <= LOAD;
                        ld_words  <= '0;
                        ld_ready  <= 1'b1;
                        mem_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD;
                    ld_ready  <= 1'b1;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset so a reset mid-load keeps bytes already written.
    assign wr_base = BW'({ld_words, 2'b00});

    always_ff @(posedge clk) begin
        if (xfer && !ld_start) begin
            for (int k = 0; k < 4; k++) begin
                mem[wr_base + BW'(k)] <= ld_data[8*k +: 8];
            end
        end
    end

    // Range check on the full 32-bit offset before narrowing to a byte index.
    assign offset   = ins_addr - 32'(INS_START);
    assign in_range = (ins_addr >= 32'(INS_START)) && (offset <= 32'(NBYTES - 4));
    assign rd_idx   = offset[BW-1:0];

    assign ins_data = (mem_ready && in_range) ?
                      {mem[rd_idx + BW'(3)], mem[rd_idx + BW'(2)],
                       mem[rd_idx + BW'(1)], mem[rd_idx]} : 32'h0;

`ifdef INS_MEM_FAULT_EN
    assign ins_fault = mem_ready && (!in_range || (ins_addr[1:0] != 2'b00));
`else
    assign ins_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ins_mem.sv
// tb/tb_ins_mem.sv - randomized self-checking bench for ins_mem against a byte-array model
module tb_ins_mem;
    localparam int DEPTH     = 40;
    localparam int INS_START = 64;
    localparam int AW        = 6;
    localparam int NBYTES    = DEPTH * 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   ins_addr = 32'h0;
    logic [31:0]   ins_data;
    logic          ins_fault;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = 32'h0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_words;
    logic          mem_ready;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_mem [NBYTES];
    int         model_words;
    bit         model_run;

    ins_mem #(.DEPTH(DEPTH), .INS_START(INS_START), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .ins_addr(ins_addr), .ins_data(ins_data),
        .ins_fault(ins_fault), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_words(ld_words), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_words"}, 32'(ld_words), 32'(model_words));
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'(!model_run));
        check({tag, "_mem_ready"}, 32'(mem_ready), 32'(model_run));
    endtask

    // One clock cycle with the given loader inputs; the model applies the loader rules afterwards.
    task automatic step(input bit valid, input logic [31:0] data, input bit last, input bit start);
        ld_valid = valid;
        ld_data  = data;
        ld_last  = last;
        ld_start = start;
        @(posedge clk);
        #1;
        if (start) begin
            model_words = 0;
            model_run   = 0;
        end else if (!model_run && valid) begin
            for (int k = 0; k < 4; k++) model_mem[model_words*4 + k] = data[8*k +: 8];
            model_words++;
            if (last || model_words == DEPTH) model_run = 1;
        end
        ld_valid = 0;
        ld_last  = 0;
        ld_start = 0;
    endtask

    function automatic logic [31:0] expect_data(input logic [31:0] addr);
        longint a;
        a = longint'(addr) - INS_START;
        if (!model_run || a < 0 || a + 3 > NBYTES - 1) return 32'h0;
        return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
    endfunction

    function automatic logic expect_fault(input logic [31:0] addr);
`ifdef INS_MEM_FAULT_EN
        longint a;
        a = longint'(addr) - INS_START;
        return model_run && (a < 0 || a + 3 > NBYTES - 1 || addr[1:0] != 2'b00);
`else
        return addr[0] & 1'b0;
`endif
    endfunction

    task automatic fetch(input string tag, input logic [31:0] addr);
        ins_addr = addr;
        #1;
        check({tag, "_data"}, ins_data, expect_data(addr));
        check({tag, "_fault"}, 32'(ins_fault), 32'(expect_fault(addr)));
    endtask

    initial begin
        model_words = 0;
        model_run   = 0;
        for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;

        // Reset state
        ins_addr = 32'd64;
        #12;
        check_status("reset");
        check("reset_data", ins_data, 32'h0);
        check("reset_fault", 32'(ins_fault), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full load, forced RUN after word 39
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 32'h13 + 32'(i), 0, 0);
            if (i < DEPTH - 1) check("full_in_load", 32'(mem_ready), 32'h0);
        end
        check_status("full_done");
        check("full_words40", 32'(ld_words), 32'd40);
        ins_addr = 32'd64; #1;
        check("full_addr64", ins_data, 32'h00000013);
        ins_addr = 32'd112; #1;
        check("full_addr112", ins_data, 32'h0000001F);
        step(1, 32'hFFFFFFFF, 0, 0);
        check_status("run_ignores_valid");
        fetch("full_w0_again", 32'd64);

        // Reload: mem_ready and ins_data drop the cycle after ld_start
        step(0, 0, 0, 1);
        check_status("reload");
        ins_addr = 32'd64; #1;
        check("reload_data_zero", ins_data, 32'h0);

        // Short load with gaps in ld_valid
        step(1, 32'hAABBCCDD, 0, 0);
        step(0, 32'h99999999, 0, 0);
        check_status("gap1");
        step(1, 32'h11223344, 0, 0);
        step(0, 32'h99999999, 1, 0);
        step(0, 32'h99999999, 0, 0);
        check_status("gap2");
        step(1, 32'h55667788, 1, 0);
        check_status("short_done");
        ins_addr = 32'd68; #1;
        check("short_addr68", ins_data, 32'h11223344);
        ins_addr = 32'd66; #1;
        check("short_addr66", ins_data, 32'h3344AABB);
        fetch("short_mis66", 32'd66);
        fetch("oor_60", 32'd60);
        fetch("oor_224", 32'd224);
        fetch("oor_221", 32'd221);
        fetch("edge_220", 32'd220);
        fetch("edge_63", 32'd63);
        fetch("oor_huge", 32'hFFFFFFFE);

        // ld_start coincident with a valid word in LOAD
        step(0, 0, 0, 1);
        step(1, 32'h01010101, 0, 0);
        step(1, 32'hDEADBEEF, 0, 1);
        check_status("start_wins");
        check("start_wins_zero", 32'(ld_words), 32'h0);

        // Two words then asynchronous reset mid-cycle
        step(1, 32'hCAFEF00D, 0, 0);
        step(1, 32'h0BADC0DE, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_words = 0;
        model_run   = 0;
        check_status("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 32'h12345678, 1, 0);
        check_status("after_reset_load");
        ins_addr = 32'd68; #1;
        check("kept_word1", ins_data, 32'h0BADC0DE);
        fetch("kept_word0", 32'd64);

        // Randomized loads and fetches
        for (int r = 0; r < 12; r++) begin
            int len;
            int sent;
            int guard;
            step(0, 0, 0, 1);
            len   = $urandom_range(1, DEPTH);
            sent  = 0;
            guard = 0;
            while (!model_run && guard < 400) begin
                bit v;
                v = ($urandom_range(0, 3) != 0);
                step(v, $urandom, v && (sent == len - 1), ($urandom_range(0, 60) == 0));
                if (ld_start == 0 && v) sent = model_words;
                guard++;
            end
            check_status("rand_load");
            for (int f = 0; f < 20; f++) begin
                fetch("rand_fetch", 32'($urandom_range(56, 232)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
